// File: rtl/max7000s_config_pkg.sv
// Shared types and constants for the MAX7000S configuration loader.
package max7000s_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int TOTAL_BIT_COUNT_DEFAULT = 15033;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [15:0] CRC16_INIT        = 16'hFFFF;

    function automatic int calc_byte_count(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Byte-wide combinational CRC-16/CCITT update, MSB first, no reflection.
// Only present when CONFIG_CRC_CHECK_EN is defined.
`ifdef CONFIG_CRC_CHECK_EN
module crc16_ccitt_byte
    import max7000s_config_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {i_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[15] ? ({w_crc[14:0], 1'b0} ^ CRC16_POLY) : {w_crc[14:0], 1'b0};
        end
    end

    assign o_crc = w_crc;

endmodule
`endif

// File: rtl/max7000s_bitstream_loader.sv
// Byte-stream to parallel bitstream loader for the EPM7032S model.
// Optional CRC-16 trailer check enabled by defining CONFIG_CRC_CHECK_EN.
module max7000s_bitstream_loader
    import max7000s_config_pkg::*;
#(
    parameter int         TOTAL_BIT_COUNT = TOTAL_BIT_COUNT_DEFAULT,
    parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [TOTAL_BIT_COUNT-1:0] bitstream,
    output logic                       config_valid,
    output logic                       busy,
    output logic                       error,
    output logic [10:0]                bytes_loaded
);

    localparam int          BYTE_COUNT = calc_byte_count(TOTAL_BIT_COUNT);
    localparam int          SHIFT_W    = BYTE_COUNT * 8;
    localparam int          PAD        = SHIFT_W - TOTAL_BIT_COUNT;
    localparam logic [10:0] LAST_COUNT = 11'(BYTE_COUNT);

    state_t                     r_state;
    logic                       r_busy;
    logic                       r_config_valid;
    logic [10:0]                r_bytes_loaded;
    logic [SHIFT_W-1:0]         r_shift;
    logic [TOTAL_BIT_COUNT-1:0] r_bitstream;
    logic                       w_xfer;
    logic                       w_start;

`ifdef CONFIG_CRC_CHECK_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;
    logic [7:0]  r_crc_hi;
    logic        r_crc_idx;
    logic        r_error;

    crc16_ccitt_byte u_crc (
        .i_crc  (r_crc),
        .i_data (in_data),
        .o_crc  (w_crc_next)
    );

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // abort must block acceptance in the very cycle it is asserted
    assign in_ready     = r_busy && !abort;
    assign w_xfer       = in_valid && in_ready;
    assign w_start      = start && !abort;
    assign busy         = r_busy;
    assign config_valid = r_config_valid;
    assign bytes_loaded = r_bytes_loaded;
    assign bitstream    = r_bitstream;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_config_valid <= 1'b0;
            r_bytes_loaded <= '0;
            r_bitstream    <= '0;
`ifdef CONFIG_CRC_CHECK_EN
            r_error        <= 1'b0;
            r_crc          <= CRC16_INIT;
            r_crc_hi       <= '0;
            r_crc_idx      <= 1'b0;
`endif
        end else if (w_start && !r_busy) begin
            r_state        <= ST_SYNC;
            r_busy         <= 1'b1;
            r_config_valid <= 1'b0;
            r_bytes_loaded <= '0;
`ifdef CONFIG_CRC_CHECK_EN
            r_error        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_xfer && in_data == SYNC_BYTE) begin
                        r_state <= ST_LOAD;
`ifdef CONFIG_CRC_CHECK_EN
                        r_crc     <= CRC16_INIT;
                        r_crc_idx <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        r_shift <= {r_shift[SHIFT_W-9:0], in_data};
                        if (r_bytes_loaded != LAST_COUNT) begin
                            r_bytes_loaded <= r_bytes_loaded + 11'd1;
                        end
`ifdef CONFIG_CRC_CHECK_EN
                        r_crc <= w_crc_next;
                        if (r_bytes_loaded == LAST_COUNT - 11'd1) begin
                            r_state <= ST_CHECK;
                        end
`else
                        // Pad bits of the final byte sit below the kept window and fall away here
                        if (r_bytes_loaded == LAST_COUNT - 11'd1) begin
                            r_state        <= ST_DONE;
                            r_busy         <= 1'b0;
                            r_config_valid <= 1'b1;
                            r_bitstream    <= TOTAL_BIT_COUNT'({r_shift, in_data} >> PAD);
                        end
`endif
                    end
                end
`ifdef CONFIG_CRC_CHECK_EN
                ST_CHECK: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        if (!r_crc_idx) begin
                            r_crc_hi  <= in_data;
                            r_crc_idx <= 1'b1;
                        end else begin
                            r_busy <= 1'b0;
                            if ({r_crc_hi, in_data} == r_crc) begin
                                r_state        <= ST_DONE;
                                r_config_valid <= 1'b1;
                                r_bitstream    <= TOTAL_BIT_COUNT'(r_shift >> PAD);
                            end else begin
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end
                        end
                    end
                end
                ST_ERROR: begin
                end
`endif
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max7000s_bitstream_loader.sv
// Scoreboard bench for max7000s_bitstream_loader with a byte-array reference model.
// Also exercises the CRC trailer when CONFIG_CRC_CHECK_EN is defined.
module tb_max7000s_bitstream_loader;
    import max7000s_config_pkg::*;

    localparam int         T  = TOTAL_BIT_COUNT_DEFAULT;
    localparam int         BC = (T + 7) / 8;
    localparam logic [7:0] SB = 8'hA5;
`ifdef CONFIG_CRC_CHECK_EN
    localparam int CM = 1;
`else
    localparam int CM = 0;
`endif

    logic         clock;
    logic         reset;
    logic         start;
    logic         abort;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [T-1:0] bitstream;
    logic         config_valid;
    logic         busy;
    logic         error;
    logic [10:0]  bytes_loaded;

    max7000s_bitstream_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bitstream    (bitstream),
        .config_valid (config_valid),
        .busy         (busy),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    typedef struct {
        logic [T-1:0] bits;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   pay[BC];
    logic [T-1:0] last_bits;
    int           checks;
    int           errors;
    logic         prev_cv;
    logic         prev_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_bits(input string name, input logic [T-1:0] act, input logic [T-1:0] expv);
        checks++;
        if (act !== expv) begin
            int idx;
            idx = -1;
            for (int k = T - 1; k >= 0; k--) begin
                if (idx < 0 && act[k] !== expv[k]) idx = k;
            end
            errors++;
            $display("FAIL %s: first differing bit %0d got %b expected %b", name, idx, act[idx], expv[idx]);
        end
    endtask

    // Bit k of the stream (k = 0 first on the wire) is bit 7-(k%8) of payload byte k/8
    function automatic logic [T-1:0] model_bits();
        logic [T-1:0] r;
        r = '0;
        for (int k = 0; k < T; k++) r[T-1-k] = pay[k/8][7-(k%8)];
        return r;
    endfunction

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < BC; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ pay[i][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] junk();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SB) b = 8'h5A;
        return b;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && ((config_valid && !prev_cv) || (error && !prev_err))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: config_valid=%0b error=%0b with no load pending", config_valid, error);
            end else begin
                e = exp_q.pop_front();
                chk("done_error_flag", 32'(error), 32'(e.err));
                chk("done_config_valid", 32'(config_valid), 32'(!e.err));
                chk("done_busy", 32'(busy), 32'd0);
                chk_bits("done_bitstream", bitstream, e.bits);
            end
        end
        prev_cv  = config_valid;
        prev_err = error;
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit done;
        int guard;
        done  = 0;
        guard = 0;
        while (!done) begin
            @(negedge clock);
            in_data  = b;
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            done = in_valid && in_ready;
            guard++;
            if (!done && guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted, in_ready=%0b", b, in_ready);
                done = 1;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: %0d loads still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_load(input int junk_mode, input bit rnd, input int crc_mode, input bit mid_start);
        exp_t        e;
        logic [15:0] c;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        e.bits = model_bits();
        e.err  = (crc_mode == 2);
        if (e.err) e.bits = last_bits;
        else last_bits = e.bits;
        exp_q.push_back(e);
        if (junk_mode == 1) begin
            send_byte(8'h00, rnd);
            send_byte(8'h13, rnd);
        end else begin
            repeat ($urandom_range(0, 3)) send_byte(junk(), rnd);
        end
        send_byte(SB, rnd);
        for (int i = 0; i < BC; i++) begin
            if (mid_start && i == 10) begin
                @(negedge clock);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clock);
                start = 1'b0;
                chk("start_ignored_busy", 32'(busy), 32'd1);
                chk("start_ignored_count", 32'(bytes_loaded), 32'd10);
            end
            send_byte(pay[i], rnd);
        end
        if (crc_mode != 0) begin
            c = model_crc();
            if (crc_mode == 2) c = c ^ (16'd1 << $urandom_range(0, 15));
            send_byte(c[15:8], rnd);
            send_byte(c[7:0], rnd);
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("done_latency", 32'(config_valid), 32'(!e.err));
        chk("done_bytes_loaded", 32'(bytes_loaded), 32'(BC));
        wait_drain();
    endtask

    task automatic partial_load(input int n);
        pulse_start();
        send_byte(SB, 1'b0);
        for (int i = 0; i < n; i++) send_byte(pay[i], 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk_bits({tag, "_bitstream"}, bitstream, '0);
        chk({tag, "_config_valid"}, 32'(config_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_bytes_loaded"}, 32'(bytes_loaded), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [T-1:0] v;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        checks    = 0;
        errors    = 0;
        last_bits = '0;
        prev_cv   = 1'b0;
        prev_err  = 1'b0;
        repeat (3) @(negedge clock);
        reset_checks("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < BC; i++) pay[i] = 8'hFF;
        run_load(1, 1'b0, CM, 1'b0);
        v = '1;
        chk_bits("all_ones", bitstream, v);

        for (int i = 0; i < BC; i++) pay[i] = 8'h00;
        pay[0]    = 8'h80;
        pay[BC-1] = 8'h7F;
        run_load(0, 1'b0, CM, 1'b0);
        v = '0;
        v[T-1] = 1'b1;
        chk_bits("msb_only_pad_ignored", bitstream, v);

        for (int i = 0; i < BC; i++) pay[i] = 8'($urandom);
        partial_load(100);
        @(negedge clock);
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_config_valid", 32'(config_valid), 32'd0);
        chk("abort_bytes_loaded", 32'(bytes_loaded), 32'd100);
        chk("abort_idle_ready", 32'(in_ready), 32'd0);
        chk_bits("abort_bitstream_held", bitstream, last_bits);

        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);

        for (int i = 0; i < BC; i++) pay[i] = 8'($urandom);
        run_load(0, 1'b1, CM, 1'b1);
        run_load(0, 1'b0, CM, 1'b0);

        for (int i = 0; i < BC; i++) pay[i] = 8'($urandom);
        partial_load(500);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset_checks("midload_reset");
        reset     = 1'b0;
        last_bits = '0;
        run_load(0, 1'b1, CM, 1'b0);

`ifdef CONFIG_CRC_CHECK_EN
        for (int i = 0; i < BC; i++) pay[i] = 8'($urandom);
        run_load(0, 1'b0, 2, 1'b0);
        chk("crc_bad_error", 32'(error), 32'd1);
        pulse_start();
        chk("crc_start_clears_error", 32'(error), 32'd0);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        run_load(0, 1'b1, 1, 1'b0);
        chk("crc_good_error", 32'(error), 32'd0);
`endif

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
